// File: rtl/rgb_led_decoder.sv
// Receive-side monitor for the three-wire RGB LED interface: decodes RED/GREEN/BLUE/BLINK mode,
// reports mode changes, dwell time and protocol errors. Optional: RGB_DECODE_GLITCH_FILTER_EN.
module rgb_led_decoder #(
    parameter int DWELL_W   = 10,
    parameter int BLINK_MIN = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               red,
    input  logic               green,
    input  logic               blue,
    input  logic               clear,
    output logic [2:0]         mode,
    output logic               mode_valid,
    output logic               change,
    output logic [DWELL_W-1:0] dwell,
    output logic               seq_err,
    output logic               err_illegal,
    output logic [2:0]         dbg_state
);

    // Solid-colour encodings equal their reported mode; BLINK_CHK reports as BLUE.
    typedef enum logic [2:0] {
        UNKNOWN   = 3'd0,
        S_RED     = 3'd1,
        S_GREEN   = 3'd2,
        S_BLUE    = 3'd3,
        S_BLINK   = 3'd4,
        BLINK_CHK = 3'd5,
        ERROR     = 3'd7
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_MAX = {DWELL_W{1'b1}};

    function automatic logic [2:0] mode_of(input state_t s);
        return (s == BLINK_CHK) ? 3'd3 : 3'(s);
    endfunction

    state_t             r_state;
    logic [2:0]         r_sample;
    logic [3:0]         r_count;
    logic               r_last_w;
    logic               r_change;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_seq_err;
    logic               r_err_illegal;

    state_t             w_next_state;
    state_t             w_target;
    logic [3:0]         w_next_count;
    logic [3:0]         w_count_inc;
    logic               w_next_last_w;
    logic               w_next_seq;
    logic               w_next_err;
    logic               w_mode_changes;
    logic               w_is_r;
    logic               w_is_g;
    logic               w_is_b;
    logic               w_is_w;
    logic               w_is_d;
    logic               w_is_dw;
    logic               w_illegal;
    logic               w_solid_ok;

    assign w_is_r      = (r_sample == 3'b100);
    assign w_is_g      = (r_sample == 3'b010);
    assign w_is_b      = (r_sample == 3'b001);
    assign w_is_w      = (r_sample == 3'b111);
    assign w_is_d      = (r_sample == 3'b000);
    assign w_is_dw     = w_is_w | w_is_d;
    assign w_illegal   = ~(w_is_r | w_is_g | w_is_b | w_is_dw);
    assign w_count_inc = r_count + 4'd1;

`ifdef RGB_DECODE_GLITCH_FILTER_EN
    // A solid colour only acts once it has been seen on two consecutive samples.
    logic [2:0] r_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev <= 3'b000;
        end else begin
            r_prev <= r_sample;
        end
    end

    assign w_solid_ok = (r_sample == r_prev);
`else
    assign w_solid_ok = 1'b1;
`endif

    always_comb begin
        w_next_state  = r_state;
        w_next_count  = r_count;
        w_next_last_w = r_last_w;
        w_next_seq    = 1'b0;
        w_next_err    = r_err_illegal;
        w_target      = S_BLUE;
        if (w_illegal) begin
            w_next_state = ERROR;
            w_next_err   = 1'b1;
        end else if (r_state == ERROR) begin
            if (clear) begin
                w_next_state = UNKNOWN;
                w_next_err   = 1'b0;
            end
        end else begin
            if (clear) begin
                w_next_err = 1'b0;
            end
            if (w_is_dw) begin
                w_next_last_w = w_is_w;
                case (r_state)
                    S_RED, S_GREEN: w_next_state = ERROR;
                    S_BLUE: begin
                        w_next_state = BLINK_CHK;
                        w_next_count = 4'd1;
                    end
                    BLINK_CHK: begin
                        if (w_is_w != r_last_w) begin
                            w_next_count = w_count_inc;
                            if (w_count_inc == 4'(BLINK_MIN)) begin
                                w_next_state = S_BLINK;
                            end
                        end else begin
                            w_next_state = ERROR;
                        end
                    end
                    S_BLINK: begin
                        if (w_is_w == r_last_w) begin
                            w_next_state = ERROR;
                        end
                    end
                    default: ;
                endcase
            end else if (w_solid_ok) begin
                if (w_is_r) begin
                    w_target = S_RED;
                end else if (w_is_g) begin
                    w_target = S_GREEN;
                end
                w_next_state = w_target;
                // Legal order is RED -> GREEN -> BLUE -> BLINK -> RED; anything else flags seq_err.
                case (r_state)
                    S_RED:             w_next_seq = (w_target == S_BLUE);
                    S_GREEN:           w_next_seq = (w_target == S_RED);
                    S_BLUE, BLINK_CHK: w_next_seq = (w_target != S_BLUE);
                    S_BLINK:           w_next_seq = (w_target != S_RED);
                    default:           w_next_seq = 1'b0;
                endcase
            end
        end
    end

    assign w_mode_changes = (mode_of(w_next_state) != mode_of(r_state));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= UNKNOWN;
            r_sample      <= 3'b000;
            r_count       <= 4'd0;
            r_last_w      <= 1'b0;
            r_change      <= 1'b0;
            r_dwell       <= '0;
            r_seq_err     <= 1'b0;
            r_err_illegal <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_sample      <= {red, green, blue};
            r_count       <= w_next_count;
            r_last_w      <= w_next_last_w;
            r_change      <= w_mode_changes;
            r_seq_err     <= w_next_seq;
            r_err_illegal <= w_next_err;
            if (w_mode_changes) begin
                r_dwell <= '0;
            end else if (r_dwell != DWELL_MAX) begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    assign mode        = mode_of(r_state);
    assign mode_valid  = (mode != 3'd0) && (mode <= 3'd4);
    assign change      = r_change;
    assign dwell       = r_dwell;
    assign seq_err     = r_seq_err;
    assign err_illegal = r_err_illegal;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_rgb_led_decoder.sv
// Self-checking bench for rgb_led_decoder: directed vectors, a sample-level behavioural
// model compared every cycle, and hand-computed literal expectations.
module tb_rgb_led_decoder;

    localparam int DWELL_W   = 10;
    localparam int BLINK_MIN = 4;
    localparam int DWELL_SAT = (1 << DWELL_W) - 1;
`ifdef RGB_DECODE_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
    localparam int LAT  = 3;
`else
    localparam bit FILT = 1'b0;
    localparam int LAT  = 2;
`endif

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               red   = 1'b0;
    logic               green = 1'b0;
    logic               blue  = 1'b0;
    logic               clear = 1'b0;
    logic [2:0]         mode;
    logic               mode_valid;
    logic               change;
    logic [DWELL_W-1:0] dwell;
    logic               seq_err;
    logic               err_illegal;
    logic [2:0]         dbg_state;

    rgb_led_decoder #(.DWELL_W(DWELL_W), .BLINK_MIN(BLINK_MIN)) dut (
        .clock(clock), .reset(reset), .red(red), .green(green), .blue(blue),
        .clear(clear), .mode(mode), .mode_valid(mode_valid), .change(change),
        .dwell(dwell), .seq_err(seq_err), .err_illegal(err_illegal),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int n_change = 0;
    int n_seq    = 0;
    bit m_live   = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Works on modes directly; m_alt > 0 while in mode 3 means a blink is being confirmed.
    int         m_mode, m_alt, m_dwell;
    bit         m_last_w, m_change, m_seq, m_err;
    logic [2:0] m_samp, m_prev;

    function automatic int succ(input int m);
        case (m)
            1: return 2;
            2: return 3;
            4: return 1;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_alt = 0; m_dwell = 0; m_last_w = 0;
        m_change = 0; m_seq = 0; m_err = 0; m_samp = 3'b000; m_prev = 3'b000;
    endtask

    task automatic model_step();
        logic [2:0] s;
        bit solid, dw, ill, w;
        int nm, t;
        s     = m_samp;
        solid = (s == 3'b100) || (s == 3'b010) || (s == 3'b001);
        dw    = (s == 3'b000) || (s == 3'b111);
        ill   = !(solid || dw);
        w     = (s == 3'b111);
        nm    = m_mode;
        m_seq = 0;
        if (ill) begin
            nm = 7; m_err = 1;
        end else if (m_mode == 7) begin
            if (clear) begin nm = 0; m_err = 0; end
        end else begin
            if (clear) m_err = 0;
            if (dw) begin
                if (m_mode == 1 || m_mode == 2) nm = 7;
                else if (m_mode == 3) begin
                    if (m_alt == 0) m_alt = 1;
                    else if (w == m_last_w) nm = 7;
                    else begin
                        m_alt++;
                        if (m_alt >= BLINK_MIN) nm = 4;
                    end
                end else if (m_mode == 4) begin
                    if (w == m_last_w) nm = 7;
                end
                m_last_w = w;
            end else if (!(FILT && s != m_prev)) begin
                t = s[2] ? 1 : (s[1] ? 2 : 3);
                m_seq = !(m_mode == 0 || t == m_mode || t == succ(m_mode));
                nm = t;
                m_alt = 0;
            end
        end
        if (nm != 3) m_alt = 0;
        m_change = (nm != m_mode);
        m_dwell  = m_change ? 0 : ((m_dwell == DWELL_SAT) ? DWELL_SAT : m_dwell + 1);
        m_mode   = nm;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or posedge reset);
            if (reset) model_reset();
            else begin
                model_step();
                m_prev = m_samp;
                m_samp = {red, green, blue};
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (m_live && !reset) begin
                chk("cmp_mode", mode, m_mode);
                chk("cmp_mode_valid", mode_valid, (m_mode >= 1 && m_mode <= 4));
                chk("cmp_change", change, m_change);
                chk("cmp_dwell", dwell, m_dwell);
                chk("cmp_seq_err", seq_err, m_seq);
                chk("cmp_err_illegal", err_illegal, m_err);
                if (change === 1'b1) n_change++;
                if (seq_err === 1'b1) n_seq++;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step(input logic [2:0] rgb, input logic clr);
        @(negedge clock);
        {red, green, blue} = rgb;
        clear = clr;
    endtask

    task automatic hold(input logic [2:0] rgb, input int n);
        for (int i = 0; i < n; i++) step(rgb, 1'b0);
    endtask

    task automatic do_reset(input bit check_literals);
        m_live = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        {red, green, blue} = 3'b000;
        clear = 1'b0;
        repeat (3) @(negedge clock);
        if (check_literals) begin
            chk("rst_mode", mode, 0);
            chk("rst_mode_valid", mode_valid, 0);
            chk("rst_change", change, 0);
            chk("rst_dwell", dwell, 0);
            chk("rst_seq_err", seq_err, 0);
            chk("rst_err_illegal", err_illegal, 0);
        end
        reset = 1'b0;
        m_live = 1'b1;
    endtask

    typedef struct packed {
        logic [2:0] rgb;
        logic       clr;
        logic [7:0] n;
    } vec_t;

    vec_t tab [35];

    initial begin
        int c0, s0;
        tab = '{
            {3'b100, 1'b0, 8'd3}, {3'b010, 1'b0, 8'd3}, {3'b100, 1'b0, 8'd3},
            {3'b010, 1'b0, 8'd3}, {3'b001, 1'b0, 8'd3}, {3'b000, 1'b0, 8'd1},
            {3'b111, 1'b0, 8'd1}, {3'b001, 1'b0, 8'd3}, {3'b000, 1'b0, 8'd1},
            {3'b000, 1'b0, 8'd2}, {3'b000, 1'b1, 8'd1}, {3'b111, 1'b0, 8'd3},
            {3'b010, 1'b0, 8'd3}, {3'b000, 1'b0, 8'd2}, {3'b100, 1'b1, 8'd1},
            {3'b100, 1'b0, 8'd3}, {3'b001, 1'b0, 8'd3}, {3'b111, 1'b0, 8'd1},
            {3'b000, 1'b0, 8'd1}, {3'b111, 1'b0, 8'd1}, {3'b000, 1'b0, 8'd1},
            {3'b111, 1'b0, 8'd1}, {3'b010, 1'b0, 8'd3}, {3'b011, 1'b0, 8'd1},
            {3'b011, 1'b1, 8'd1}, {3'b100, 1'b1, 8'd1}, {3'b100, 1'b0, 8'd2},
            {3'b100, 1'b1, 8'd2}, {3'b101, 1'b0, 8'd1}, {3'b001, 1'b0, 8'd3},
            {3'b001, 1'b1, 8'd1}, {3'b001, 1'b0, 8'd3}, {3'b010, 1'b0, 8'd1},
            {3'b100, 1'b0, 8'd3}, {3'b000, 1'b0, 8'd2}
        };

        // Reset values, then a held RED.
        do_reset(1'b1);
        hold(3'b000, 2);
        step(3'b100, 1'b0);
        repeat (LAT) @(posedge clock);
        #1;
        chk("red_mode", mode, 1);
        chk("red_change", change, 1);
        chk("red_dwell0", dwell, 0);
        @(posedge clock); #1;
        chk("red_change_off", change, 0);
        chk("red_dwell1", dwell, 1);
        @(posedge clock); #1;
        chk("red_dwell2", dwell, 2);

        // Full legal cycle R, G, B, blink, back to R.
        do_reset(1'b0);
        c0 = n_change; s0 = n_seq;
        hold(3'b100, 5);
        hold(3'b010, 5);
        hold(3'b001, 120);
        for (int i = 0; i < 8; i++) step((i % 2 == 0) ? 3'b000 : 3'b111, 1'b0);
        @(posedge clock); #1;
        chk("cycle_blink_mode", mode, 4);
        hold(3'b100, 5);
        @(posedge clock); #1;
        chk("cycle_end_mode", mode, 1);
        chk("cycle_changes", n_change - c0, 5);
        chk("cycle_seq_errs", n_seq - s0, 0);
        chk("cycle_err_illegal", err_illegal, 0);

        // RED straight to BLUE is out of order.
        do_reset(1'b0);
        hold(3'b100, 3);
        s0 = n_seq;
        hold(3'b001, 4);
        @(posedge clock); #1;
        chk("skip_mode", mode, 3);
        chk("skip_seq_errs", n_seq - s0, 1);
        chk("skip_err_illegal", err_illegal, 0);

        // Illegal code from GREEN, clear colliding with it, then a real clear.
        do_reset(1'b0);
        hold(3'b100, 3);
        hold(3'b010, 3);
        step(3'b110, 1'b0);
        step(3'b010, 1'b1);
        step(3'b010, 1'b0);
        chk("ill_mode", mode, 7);
        chk("ill_err_sticky", err_illegal, 1);
        step(3'b010, 1'b1);
        step(3'b010, 1'b0);
        chk("ill_clear_mode", mode, 0);
        chk("ill_clear_err", err_illegal, 0);

        // Repeated white while blinking.
        do_reset(1'b0);
        hold(3'b100, 3);
        hold(3'b010, 3);
        hold(3'b001, 3);
        for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 3'b000 : 3'b111, 1'b0);
        step(3'b111, 1'b0);
        step(3'b111, 1'b0);
        @(posedge clock); #1;
        chk("rep_mode", mode, 7);
        chk("rep_err_illegal", err_illegal, 0);
        step(3'b111, 1'b1);
        step(3'b111, 1'b0);
        @(posedge clock); #1;
        chk("rep_clear_mode", mode, 0);

`ifdef RGB_DECODE_GLITCH_FILTER_EN
        // Single-cycle GREEN glitch is dropped; a two-cycle GREEN commits.
        do_reset(1'b0);
        hold(3'b100, 4);
        c0 = n_change; s0 = n_seq;
        step(3'b010, 1'b0);
        hold(3'b100, 4);
        @(posedge clock); #1;
        chk("glitch_mode", mode, 1);
        chk("glitch_changes", n_change - c0, 0);
        chk("glitch_seq_errs", n_seq - s0, 0);
        step(3'b010, 1'b0);
        step(3'b010, 1'b0);
        @(posedge clock); #1;
        chk("glitch_g2_early", mode, 1);
        @(posedge clock); #1;
        chk("glitch_g2_mode", mode, 2);
        chk("glitch_g2_change", change, 1);
`endif

        // Mixed directed table, checked by the model every cycle.
        do_reset(1'b0);
        for (int i = 0; i < 35; i++) begin
            step(tab[i].rgb, tab[i].clr);
            for (int j = 1; j < int'(tab[i].n); j++) step(tab[i].rgb, 1'b0);
        end

        // Dwell saturation while idling in UNKNOWN.
        do_reset(1'b0);
        hold(3'b000, 1030);
        @(posedge clock); #1;
        chk("sat_dwell", dwell, DWELL_SAT);
        chk("sat_mode", mode, 0);

        @(negedge clock);
        m_live = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
